// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: dual H-bridge PWM driver.
// Turns the signed 12-bit left/right wheel speed commands into offset-binary
// duty cycles, compares them against a free-running 2048-cycle period
// counter, and drives complementary forward/reverse legs through a per-side
// deadtime FSM so both legs of a bridge are never on together.
//
// Optional build macro: MTR_DUTY_CLAMP_EN
//   When defined, the mapped duty is clamped to [2*DEAD_CYC, 2047-2*DEAD_CYC]
//   so each leg always gets at least DEAD_CYC cycles of on-time per period.
//
// Handshake: none; speed commands are level inputs sampled once per period
// (at cnt==2047) into a shadow register, outputs are plain levels.
module mtr_pwm_drv #(
  parameter int unsigned DEAD_CYC = 16  // legal range 1..63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        en,
  output logic        lft_PWM1,
  output logic        lft_PWM2,
  output logic        rght_PWM1,
  output logic        rght_PWM2,
  output logic        PWM_synch
);

  typedef enum logic [1:0] {
    ST_DEAD = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_e;

  localparam logic [10:0] CNT_LAST  = 11'h7FF;
  localparam logic [10:0] DUTY_MID  = 11'd1024;
  localparam logic [5:0]  DCNT_LAST = 6'(DEAD_CYC - 1);

`ifdef MTR_DUTY_CLAMP_EN
  localparam logic [10:0] CLAMP_LO = 11'(2 * DEAD_CYC);
  localparam logic [10:0] CLAMP_HI = 11'(2047 - 2 * DEAD_CYC);
`endif

  // Side index 0 = left bridge, 1 = right bridge.
  logic [10:0] cnt_q;
  logic        synch_q;
  logic [10:0] duty_q  [2];
  logic        raw_q   [2];
  state_e      state_q [2];
  state_e      state_d [2];
  logic [5:0]  dcnt_q  [2];
  logic [5:0]  dcnt_d  [2];
  logic        tgt_q   [2];
  logic        tgt_d   [2];
  logic [11:0] spd     [2];

  assign spd[0] = lft_spd;
  assign spd[1] = rght_spd;

  // Signed speed to offset-binary duty: (spd >>> 1) + 1024, i.e. the top
  // eleven bits with the sign bit inverted.
  function automatic logic [10:0] map_duty(input logic [11:0] s);
    logic [10:0] d;
    d = 11'($signed(s) >>> 1) + DUTY_MID;
`ifdef MTR_DUTY_CLAMP_EN
    if (d < CLAMP_LO) begin
      d = CLAMP_LO;
    end else if (d > CLAMP_HI) begin
      d = CLAMP_HI;
    end
`endif
    return d;
  endfunction

  // Period counter, period-start strobe, duty shadows and raw compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      synch_q <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        duty_q[s] <= DUTY_MID;
        raw_q[s]  <= 1'b0;
      end
    end else begin
      cnt_q   <= cnt_q + 11'd1;
      synch_q <= (cnt_q == CNT_LAST);
      for (int s = 0; s < 2; s++) begin
        raw_q[s] <= (cnt_q < duty_q[s]);
        if (cnt_q == CNT_LAST) begin
          duty_q[s] <= map_duty(spd[s]);
        end
      end
    end
  end

  // Deadtime FSM state registers for both sides.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= ST_DEAD;
        dcnt_q[s]  <= '0;
        tgt_q[s]   <= 1'b0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        state_q[s] <= state_d[s];
        dcnt_q[s]  <= dcnt_d[s];
        tgt_q[s]   <= tgt_d[s];
      end
    end
  end

  // Next-state logic: a leg only turns on after raw_q has held its level
  // for a full DEAD window; any bounce in the window restarts it.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      state_d[s] = state_q[s];
      dcnt_d[s]  = dcnt_q[s];
      tgt_d[s]   = tgt_q[s];
      if (!en) begin
        state_d[s] = ST_DEAD;
        dcnt_d[s]  = '0;
        tgt_d[s]   = raw_q[s];
      end else begin
        case (state_q[s])
          ST_DEAD: begin
            if (raw_q[s] != tgt_q[s]) begin
              tgt_d[s]  = raw_q[s];
              dcnt_d[s] = '0;
            end else if (dcnt_q[s] == DCNT_LAST) begin
              state_d[s] = tgt_q[s] ? ST_HI : ST_LO;
            end else begin
              dcnt_d[s] = dcnt_q[s] + 6'd1;
            end
          end
          ST_HI: begin
            if (!raw_q[s]) begin
              state_d[s] = ST_DEAD;
              tgt_d[s]   = 1'b0;
              dcnt_d[s]  = '0;
            end
          end
          ST_LO: begin
            if (raw_q[s]) begin
              state_d[s] = ST_DEAD;
              tgt_d[s]   = 1'b1;
              dcnt_d[s]  = '0;
            end
          end
          default: begin
            state_d[s] = ST_DEAD;
            dcnt_d[s]  = '0;
          end
        endcase
      end
    end
  end

  // Outputs decode straight from the state flops.
  assign lft_PWM1  = (state_q[0] == ST_HI);
  assign lft_PWM2  = (state_q[0] == ST_LO);
  assign rght_PWM1 = (state_q[1] == ST_HI);
  assign rght_PWM2 = (state_q[1] == ST_LO);
  assign PWM_synch = synch_q;

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// tb_mtr_pwm_drv: randomized and directed bench for mtr_pwm_drv.
// Reference model: period counter and duty shadows as plain arithmetic; the
// deadtime behaviour as a window rule (a leg is on only when the last
// DEAD_CYC+1 raw samples all agree and enable has been high long enough).
module tb_mtr_pwm_drv;

  localparam int DC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [11:0] lft_spd, rght_spd;
  logic lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch;

  always #5 clk = ~clk;

  mtr_pwm_drv #(.DEAD_CYC(DC)) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .en        (en),
    .lft_PWM1  (lft_PWM1),
    .lft_PWM2  (lft_PWM2),
    .rght_PWM1 (rght_PWM1),
    .rght_PWM2 (rght_PWM2),
    .PWM_synch (PWM_synch)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [10:0] m_cnt;
  logic        m_synch;
  logic [10:0] m_duty [2];
  logic        m_raw  [2];
  logic [DC:0] rh     [2];  // newest raw sample in bit 0
  logic [DC:0] eh     [2];  // enable level at each sample
  int          nh     [2];

  function automatic logic [10:0] ref_duty(input logic [11:0] s);
    int v, d;
    v = int'($signed(s));
    d = (v >>> 1) + 1024;
`ifdef MTR_DUTY_CLAMP_EN
    if (d < 2 * DC) d = 2 * DC;
    if (d > 2047 - 2 * DC) d = 2047 - 2 * DC;
`endif
    return 11'(d);
  endfunction

  task automatic model_edge();
    logic [11:0] s_in [2];
    logic [1:0]  fw, rv;
    s_in[0] = lft_spd;
    s_in[1] = rght_spd;
    if (rst) begin
      m_cnt   = '0;
      m_synch = 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_duty[s] = 11'd1024;
        m_raw[s]  = 1'b0;
        rh[s]     = '0;
        eh[s]     = '0;
        nh[s]     = 1;  // reset acts as one settled low sample
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        rh[s] = {rh[s][DC-1:0], m_raw[s]};
        eh[s] = {eh[s][DC-1:0], en};
        if (nh[s] < DC + 1) nh[s]++;
        m_raw[s] = (m_cnt < m_duty[s]);
        if (m_cnt == 11'd2047) m_duty[s] = ref_duty(s_in[s]);
      end
      m_synch = (m_cnt == 11'd2047);
      m_cnt   = m_cnt + 11'd1;
    end
    for (int s = 0; s < 2; s++) begin
      fw[s] = (nh[s] == DC + 1) && (&eh[s][DC-1:0]) && (&rh[s]);
      rv[s] = (nh[s] == DC + 1) && (&eh[s][DC-1:0]) && (rh[s] == '0);
    end
    exp_q.push_back({m_synch, rv[1], fw[1], rv[0], fw[0]});
  endtask

  // ---------------- driver / monitor ----------------
  int c_l1, c_l2, c_r1, c_r2, c_sy;

  function automatic logic [4:0] dut_outs();
    return {PWM_synch, rght_PWM2, rght_PWM1, lft_PWM2, lft_PWM1};
  endfunction

  task automatic clr_counts();
    c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0; c_sy = 0;
  endtask

  task automatic step();
    logic [4:0] e, g;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    g = dut_outs();
    check_eq("outputs", 32'(g), 32'(e));
    check_eq("overlap", 32'({lft_PWM1 & lft_PWM2, rght_PWM1 & rght_PWM2}), 32'd0);
    c_l1 += int'(lft_PWM1);
    c_l2 += int'(lft_PWM2);
    c_r1 += int'(rght_PWM1);
    c_r2 += int'(rght_PWM2);
    c_sy += int'(PWM_synch);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_cnt(input logic [10:0] target);
    int guard;
    guard = 0;
    while (m_cnt != target && guard < 2048) begin
      step();
      guard++;
    end
    check_eq("cnt_reach", 32'(m_cnt), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    rst = 1'b1; en = 1'b1; lft_spd = '0; rght_spd = '0;
    run(2);
    check_eq("reset_outs", 32'(dut_outs()), 32'd0);
    rst = 1'b0;

    // zero speed: no strobe in the first period, then one per period
    clr_counts();
    run(2047);
    check_eq("no_synch_first_period", 32'(c_sy), 32'd0);
    run(1);
    check_eq("first_synch", 32'(PWM_synch), 32'd1);
    clr_counts();
    run(4096);
    check_eq("zero_l1", 32'(c_l1), 32'd2016);
    check_eq("zero_l2", 32'(c_l2), 32'd2016);
    check_eq("zero_r1", 32'(c_r1), 32'd2016);
    check_eq("zero_synch", 32'(c_sy), 32'd2);

    // full reverse left, full forward right
    lft_spd = 12'h800; rght_spd = 12'h7FF;
    run(4096);
    clr_counts();
    run(2048);
    check_eq("rev_l1", 32'(c_l1), 32'd0);
    check_eq("rev_l2", 32'(c_l2), 32'd2048);
    check_eq("fwd_r2_sum", 32'(c_r1 + c_r2 + 2 * ((c_r2 != 0) ? 16 : 0) + ((c_r2 == 0) ? 17 : 0)), 32'd2048);
`ifdef MTR_DUTY_CLAMP_EN
    check_eq("fwd_r1_clamp", 32'(c_r1), 32'd1999);
`else
    check_eq("fwd_r1", 32'(c_r1), 32'd2031);
    check_eq("fwd_r2", 32'(c_r2), 32'd0);
`endif

    // mid-period change takes effect only next period
    lft_spd = '0; rght_spd = '0;
    run(4096);
    clr_counts();
    run_to_cnt(11'd500);
    lft_spd = 12'h200;
    run_to_cnt(11'd0);
    check_eq("mid_change_cur", 32'(c_l1), 32'd1008);
    clr_counts();
    run(2048);
    check_eq("mid_change_next_l1", 32'(c_l1), 32'd1264);
    check_eq("mid_change_next_l2", 32'(c_l2), 32'd752);

    // enable toggle inside the raw-high stretch (lft duty 1280)
    run_to_cnt(11'd300);
    en = 1'b0;
    step();
    check_eq("en_off_next", 32'(dut_outs() & 5'h0F), 32'd0);
    run(5);
    en = 1'b1;
    clr_counts();
    run(15);
    check_eq("en_rise_low", 32'(c_l1 + c_l2 + c_r1 + c_r2), 32'd0);
    step();
    check_eq("en_rise_follow", 32'(lft_PWM1), 32'd1);

    // randomized speeds and enable
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 5))
        0: lft_spd = 12'h800;
        1: lft_spd = 12'h7FF;
        default: lft_spd = 12'($urandom);
      endcase
      rght_spd = 12'($urandom);
      en = ($urandom_range(0, 3) != 0);
      run($urandom_range(3, 1200));
    end
    en = 1'b1;

    // reset while the left forward leg is on
    lft_spd = 12'h400; rght_spd = 12'($urandom);
    run(4096);
    guard = 0;
    while (!lft_PWM1 && guard < 2048) begin
      step();
      guard++;
    end
    check_eq("hi_reached", 32'(lft_PWM1), 32'd1);
    rst = 1'b1;
    step();
    check_eq("rst_mid_outs", 32'(dut_outs()), 32'd0);
    rst = 1'b0;
    clr_counts();
    run(2047);
    check_eq("rst_no_synch", 32'(c_sy), 32'd0);
    check_eq("rst_first_duty", 32'(c_l1), 32'd1008);
    run(1);
    check_eq("rst_synch_wrap", 32'(PWM_synch), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
